// File: rtl/mole_game_core.sv
// rtl/mole_game_core.sv - whack-a-mole game core: countdown, play timer, LFSR mole spawner, scoring
// Optional MOLE_MISS_PENALTY_EN: wrong whacks pulse miss_o and cost one point.
module mole_game_core #(
    parameter int          NUM_MOLES   = 16,
    parameter int          SCORE_W     = 14,
    parameter int          GAME_TICKS  = 600,
    parameter int          COUNT_TICKS = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 tick_i,
    input  logic                 start_i,
    input  logic [1:0]           level_i,
    input  logic [NUM_MOLES-1:0] switches_i,
    output logic [NUM_MOLES-1:0] moles_o,
    output logic [SCORE_W-1:0]   score_o,
    output logic [15:0]          time_left_o,
    output logic [1:0]           state_o,
    output logic                 hit_o,
    output logic                 miss_o
);

    localparam int IDX_W = $clog2(NUM_MOLES);

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_COUNTDOWN = 2'b01;
    localparam logic [1:0] ST_PLAY      = 2'b10;
    localparam logic [1:0] ST_DONE      = 2'b11;

    localparam logic [15:0]          COUNT_LOAD = 16'(COUNT_TICKS);
    localparam logic [15:0]          GAME_LOAD  = 16'(GAME_TICKS);
    localparam logic [SCORE_W-1:0]   SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0]   SCORE_ZERO = '0;
    localparam logic [SCORE_W-1:0]   SCORE_ONE  = SCORE_W'(1);
    localparam logic [NUM_MOLES-1:0] MOLE_ONE   = NUM_MOLES'(1);

    logic [1:0]           state_q;
    logic [1:0]           level_q;
    logic [15:0]          time_q;
    logic [SCORE_W-1:0]   score_q;
    logic [NUM_MOLES-1:0] moles_q;
    logic                 hit_q;
    logic                 miss_q;
    logic [15:0]          lfsr_q;
    logic [IDX_W-1:0]     prev_idx_q;
    logic [NUM_MOLES-1:0] sw_q;
    logic                 vis_q;
    logic [3:0]           life_q;

    logic [15:0]          lfsr_next;
    logic [NUM_MOLES-1:0] whack;
    logic                 active;
    logic                 hit_now;
    logic                 wrong_now;
    logic                 miss_now;
    logic [IDX_W-1:0]     raw_idx;
    logic [IDX_W-1:0]     spawn_idx;
    logic [3:0]           life_load;
    logic                 start_ok;
    logic [SCORE_W-1:0]   score_next;

    // Right-shifting Galois form; 0xB400 holds the taps 16,14,13,11.
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // A whack is any edge on a switch, so players may flip either way.
    assign whack     = switches_i ^ sw_q;
    assign active    = (state_q == ST_PLAY) && vis_q;
    assign hit_now   = active && (|(whack & moles_q));
    assign wrong_now = active && (|(whack & ~moles_q));

`ifdef MOLE_MISS_PENALTY_EN
    assign miss_now = wrong_now && !hit_now;
`else
    assign miss_now = 1'b0;
`endif

    assign raw_idx   = lfsr_q[IDX_W-1:0];
    assign spawn_idx = (raw_idx == prev_idx_q) ? raw_idx + IDX_W'(1) : raw_idx;
    assign start_ok  = start_i && (level_i != 2'b00) &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        life_load = 4'd10;
        case (level_q)
            2'b01:   life_load = 4'd10;
            2'b10:   life_load = 4'd5;
            2'b11:   life_load = 4'd2;
            default: life_load = 4'd10;
        endcase
    end

    always_comb begin
        score_next = score_q;
        if (hit_now) begin
            if (score_q != SCORE_MAX)
                score_next = score_q + SCORE_ONE;
        end else if (miss_now) begin
            if (score_q != SCORE_ZERO)
                score_next = score_q - SCORE_ONE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            level_q    <= 2'b00;
            time_q     <= 16'd0;
            score_q    <= '0;
            moles_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            prev_idx_q <= '0;
            sw_q       <= switches_i;
            vis_q      <= 1'b0;
            life_q     <= 4'd0;
        end else begin
            lfsr_q <= lfsr_next;
            sw_q   <= switches_i;
            hit_q  <= hit_now;
            miss_q <= miss_now;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_q <= ST_COUNTDOWN;
                        level_q <= level_i;
                        score_q <= '0;
                        time_q  <= COUNT_LOAD;
                        moles_q <= '0;
                        vis_q   <= 1'b0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (tick_i) begin
                        if (time_q <= 16'd1) begin
                            state_q <= ST_PLAY;
                            time_q  <= GAME_LOAD;
                        end else begin
                            time_q <= time_q - 16'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    score_q <= score_next;
                    // Not visible means blank: the next tick spawns a fresh mole.
                    if (hit_now) begin
                        moles_q <= '0;
                        vis_q   <= 1'b0;
                    end else if (tick_i) begin
                        if (vis_q) begin
                            if (life_q <= 4'd1) begin
                                moles_q <= '0;
                                vis_q   <= 1'b0;
                            end else begin
                                life_q <= life_q - 4'd1;
                            end
                        end else begin
                            moles_q    <= MOLE_ONE << spawn_idx;
                            prev_idx_q <= spawn_idx;
                            vis_q      <= 1'b1;
                            life_q     <= life_load;
                        end
                    end
                    if (tick_i) begin
                        if (time_q <= 16'd1) begin
                            state_q <= ST_DONE;
                            time_q  <= 16'd0;
                            moles_q <= '0;
                            vis_q   <= 1'b0;
                        end else begin
                            time_q <= time_q - 16'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign moles_o     = moles_q;
    assign score_o     = score_q;
    assign time_left_o = time_q;
    assign state_o     = state_q;
    assign hit_o       = hit_q;
    assign miss_o      = miss_q;

endmodule
